// File: rtl/data_mem_pkg.sv
// Shared definitions for the handshaked data memory: funct3 codes, FSM states
// and load-data extension.
package data_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   // Align the addressed lane to bit 0, then sign- or zero-extend by access size.
   function automatic logic [31:0] extend_load(input logic [2:0]  funct3,
                                               input logic [31:0] word,
                                               input logic [1:0]  byte_off);
      logic [31:0] sh;
      sh = word >> {byte_off, 3'b000};
      case (funct3)
         F3_B:    return {{24{sh[7]}}, sh[7:0]};
         F3_H:    return {{16{sh[15]}}, sh[15:0]};
         F3_BU:   return {24'd0, sh[7:0]};
         F3_HU:   return {16'd0, sh[15:0]};
         default: return sh;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_array.sv
// Byte-lane-write, registered-read word RAM; shaped to map onto block RAM.
module data_mem_array #(
   parameter int unsigned WORDS = 1024,
   parameter int unsigned IDX_W = 10
) (
   input  logic             clk,
   input  logic             rd_en,
   input  logic [3:0]       be,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [3:0][7:0] mem [WORDS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (be[i]) mem[idx][i] <= wdata[8*i +: 8];
      end
      if (rd_en) rdata <= mem[idx];
   end

endmodule

// File: rtl/data_mem_pipe.sv
// Handshaked RV32 data memory: one outstanding load/store, fault detection,
// configurable read latency.
module data_mem_pipe
   import data_mem_pkg::*;
#(
   parameter int unsigned DEPTH_BYTES = 4096,
   parameter int unsigned READ_LAT    = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned ADDR_W = $clog2(DEPTH_BYTES);
   localparam int unsigned IDX_W  = (ADDR_W > 2) ? ADDR_W - 2 : 1;
   localparam int unsigned WORDS  = DEPTH_BYTES / 4;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               we_q, err_q;
   logic [2:0]         f3_q;
   logic [1:0]         off_q;

   logic               accept_c, legal_c, mis_c, oor_c, err_c;
   logic [1:0]         size_m1_c;
   logic [3:0]         be_c, ram_be;
   logic [31:0]        wdata_c, ram_rdata, word_c;
   logic               ram_rd_en;

   assign accept_c = req_valid && (state_q == S_IDLE);

   // Fault check: size, legality, alignment and end-of-access range.
   always_comb begin
      legal_c   = 1'b0;
      size_m1_c = 2'd0;
      case (req_funct3)
         F3_B:    begin legal_c = 1'b1;    size_m1_c = 2'd0; end
         F3_H:    begin legal_c = 1'b1;    size_m1_c = 2'd1; end
         F3_W:    begin legal_c = 1'b1;    size_m1_c = 2'd3; end
         F3_BU:   begin legal_c = !req_we; size_m1_c = 2'd0; end
         F3_HU:   begin legal_c = !req_we; size_m1_c = 2'd1; end
         default: begin legal_c = 1'b0;    size_m1_c = 2'd0; end
      endcase
      mis_c = ((size_m1_c == 2'd1) && req_addr[0]) ||
              ((size_m1_c == 2'd3) && (req_addr[1:0] != 2'b00));
      oor_c = ({1'b0, req_addr} + 33'(size_m1_c)) >= 33'(DEPTH_BYTES);
      err_c = mis_c || oor_c || !legal_c;
   end

   // Store lane alignment (little-endian).
   always_comb begin
      be_c    = 4'b0000;
      wdata_c = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            be_c    = 4'b0001 << req_addr[1:0];
            wdata_c = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be_c    = 4'b0011 << req_addr[1:0];
            wdata_c = {2{req_wdata[15:0]}};
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = req_wdata;
         end
      endcase
   end

   assign ram_be    = (accept_c && req_we && !err_c) ? be_c : 4'b0000;
   assign ram_rd_en = accept_c && !req_we && !err_c;

   data_mem_array #(
      .WORDS (WORDS),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .rd_en (ram_rd_en),
      .be    (ram_be),
      .idx   (IDX_W'(req_addr >> 2)),
      .wdata (wdata_c),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d = (req_we || err_c || (READ_LAT == 1)) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == CNT_W'(1)) state_d = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Request attributes and latency counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         we_q  <= 1'b0;
         err_q <= 1'b0;
         f3_q  <= 3'b000;
         off_q <= 2'b00;
      end else if (accept_c) begin
         we_q  <= req_we;
         err_q <= err_c;
         f3_q  <= req_funct3;
         off_q <= req_addr[1:0];
         cnt_q <= CNT_W'(READ_LAT - 1);
      end else if (state_q == S_WAIT) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Extra read stages beyond the RAM's own register; RAM output is held
   // after capture, so the stages only add delay.
   if (READ_LAT > 1) begin : g_pipe
      logic [31:0] pipe_q [READ_LAT-1];
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < int'(READ_LAT) - 1; i++) pipe_q[i] <= '0;
         end else if (state_q == S_WAIT) begin
            pipe_q[0] <= ram_rdata;
            for (int i = 1; i < int'(READ_LAT) - 1; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end
      assign word_c = pipe_q[READ_LAT-2];
   end else begin : g_nopipe
      assign word_c = ram_rdata;
   end

   assign rsp_err   = (state_q == S_RESP) && err_q;
   assign rsp_rdata = ((state_q == S_RESP) && !we_q && !err_q) ?
                      extend_load(f3_q, word_c, off_q) : 32'd0;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Self-checking bench for data_mem_pipe: directed cases plus randomized traffic
// against a byte-array reference model.
module tb_data_mem_pipe;

   localparam int unsigned DEPTH = 4096;
   localparam int unsigned LAT   = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks = 0;
   int failures = 0;
   int n_acc = 0;
   int n_rsp = 0;

   logic [7:0] ref_mem [DEPTH];

   data_mem_pipe #(
      .DEPTH_BYTES (DEPTH),
      .READ_LAT    (LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_n) begin
         if (req_valid && req_ready) n_acc++;
         if (rsp_valid && rsp_ready) n_rsp++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Reference: access size from funct3, then plain byte-array arithmetic.
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int n;
      logic legal;
      longint unsigned a;
      longint v;
      a = {32'd0, addr};
      n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
                 : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      er = !legal || (a % longint'(n) != 0) || (a + longint'(n) > longint'(DEPTH));
      rd = 32'd0;
      if (!er) begin
         if (we) begin
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
         end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[int'(a) + i]) << (8*i));
            if (!f3[2] && n < 4 && v[8*n-1]) v = v - (64'sd1 <<< (8*n));
            rd = v[31:0];
         end
      end
   endfunction

   // Drive one request from a negedge, wait for its response, hold it off
   // for 'hold' cycles, then accept it. Returns on a negedge.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
      int n;
      n = 0;
      rd = 32'd0;
      er = 1'b0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we = we;
      req_funct3 = f3;
      req_addr = addr;
      req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid) begin
         check("rsp_timeout", 32'(rsp_valid), 32'd1);
         return;
      end
      rd = rsp_rdata;
      er = rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_rdata", rsp_rdata, rd);
         check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er);
      logic [31:0] mrd;
      logic mer;
      int lat;
      model(we, f3, addr, wd, mrd, mer);
      issue(we, f3, addr, wd, hold, rd, er, lat);
      check("rdata", rd, mrd);
      check("err", 32'(er), 32'(mer));
      check("latency", 32'(lat), (we || mer) ? 32'd1 : 32'(LAT));
   endtask

   initial begin
      logic [31:0] rd;
      logic er;
      logic we;
      logic [2:0] f3;
      logic [31:0] addr;
      logic [2:0] legal_f3 [5];
      int hold;

      legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
      legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 8'h00;

      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_err", 32'(rsp_err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", 32'(req_ready), 32'd1);
      check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

      for (int a = 0; a < int'(DEPTH); a += 4) run(1'b1, 3'b010, 32'(a), 32'd0, 0, rd, er);

      // Round trip and extension
      run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er);
      check("sw_err", 32'(er), 32'd0);
      run(1'b0, 3'b010, 32'h10, 32'd0, 5, rd, er);
      check("lw_10", rd, 32'hDEADBEEF);
      check("lw_10_err", 32'(er), 32'd0);
      run(1'b0, 3'b000, 32'h13, 32'd0, 0, rd, er);
      check("lb_13", rd, 32'hFFFFFFDE);
      run(1'b0, 3'b100, 32'h13, 32'd0, 0, rd, er);
      check("lbu_13", rd, 32'h000000DE);
      run(1'b0, 3'b001, 32'h12, 32'd0, 0, rd, er);
      check("lh_12", rd, 32'hFFFFDEAD);
      run(1'b0, 3'b101, 32'h10, 32'd0, 0, rd, er);
      check("lhu_10", rd, 32'h0000BEEF);

      // Sub-word store
      run(1'b1, 3'b010, 32'h20, 32'd0, 0, rd, er);
      run(1'b1, 3'b000, 32'h21, 32'h1AB, 0, rd, er);
      run(1'b0, 3'b010, 32'h20, 32'd0, 0, rd, er);
      check("sb_merge", rd, 32'h0000AB00);

      // Faults
      run(1'b0, 3'b001, 32'h3, 32'd0, 0, rd, er);
      check("lh_mis_err", 32'(er), 32'd1);
      check("lh_mis_rdata", rd, 32'd0);
      run(1'b1, 3'b010, 32'h6, 32'h12345678, 0, rd, er);
      check("sw_mis_err", 32'(er), 32'd1);
      run(1'b0, 3'b010, 32'h4, 32'd0, 0, rd, er);
      check("sw_mis_untouched", rd, 32'd0);
      run(1'b0, 3'b010, 32'h1000, 32'd0, 0, rd, er);
      check("lw_oor_err", 32'(er), 32'd1);
      check("lw_oor_rdata", rd, 32'd0);
      run(1'b0, 3'b011, 32'h10, 32'd0, 0, rd, er);
      check("ld_ill_err", 32'(er), 32'd1);
      check("ld_ill_rdata", rd, 32'd0);
      run(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 0, rd, er);
      check("st_ill_err", 32'(er), 32'd1);
      run(1'b0, 3'b010, 32'h10, 32'd0, 0, rd, er);
      check("st_ill_untouched", rd, 32'hDEADBEEF);
      run(1'b0, 3'b010, 32'(DEPTH - 2), 32'd0, 0, rd, er);
      check("lw_top_err", 32'(er), 32'd1);
      run(1'b0, 3'b101, 32'(DEPTH - 2), 32'd0, 0, rd, er);
      check("lhu_top_err", 32'(er), 32'd0);

      // Reset while a load waits
      req_valid = 1'b1;
      req_we = 1'b0;
      req_funct3 = 3'b010;
      req_addr = 32'h10;
      @(negedge clk);
      req_valid = 1'b0;
      check("wait_rsp_valid", 32'(rsp_valid), 32'd0);
      rst_n = 1'b0;
      #1;
      check("midrst_req_ready", 32'(req_ready), 32'd1);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_rdata", rsp_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("after_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      run(1'b0, 3'b010, 32'h10, 32'd0, 0, rd, er);
      check("after_rst_data", rd, 32'hDEADBEEF);

      // Randomized mixed traffic with backpressure
      for (int k = 0; k < 10000; k++) begin
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 4)];
         else f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 9))
            0:       addr = $urandom;
            1:       addr = 32'(DEPTH - $urandom_range(1, 8));
            default: addr = 32'($urandom_range(0, 63));
         endcase
         hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         run(we, f3, addr, $urandom, hold, rd, er);
      end

      check("one_rsp_per_accept", 32'(n_acc), 32'(n_rsp + 1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
